// File: rtl/tile_transform_scheduler_if.sv
// Stream and transform-unit bus between the tile fetch/result writer side (master)
// and the tile transform scheduler (slave).
interface tile_transform_scheduler_if #(
    parameter int unsigned DATA_WIDTH = 16
);
    logic                              in_valid;
    logic                              in_ready;
    logic [DATA_WIDTH-1:0]             in_data;
    logic [0:5][0:5][DATA_WIDTH-1:0]   ttu_tile_in;
    logic [0:5][0:5][DATA_WIDTH-1:0]   ttu_tile_out;
    logic                              ttu_transform_done;
    logic                              out_valid;
    logic                              out_ready;
    logic [DATA_WIDTH-1:0]             out_data;
    logic                              out_last;

    modport master (
        output in_valid, in_data, ttu_tile_out, ttu_transform_done, out_ready,
        input  in_ready, ttu_tile_in, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, ttu_tile_out, ttu_transform_done, out_ready,
        output in_ready, ttu_tile_in, out_valid, out_data, out_last
    );
endinterface

// File: rtl/tile_transform_scheduler.sv
// Job sequencer for the 6x6 tile transform unit: load 36 elements, wait for the unit, drain 36 results.
// Optional WAIT timeout/abort is built when TTS_TIMEOUT_EN is defined.
module tile_transform_scheduler #(
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned COUNT_WIDTH    = 8,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_start,
    input  logic [COUNT_WIDTH-1:0]   i_tile_count,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_error,
    output logic [COUNT_WIDTH-1:0]   o_tiles_done,
    tile_transform_scheduler_if.slave bus
);

    localparam int unsigned IDX_W    = 3;
    localparam int unsigned LAST_IDX = 5;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_WAIT  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    typedef logic [0:5][0:5][DATA_WIDTH-1:0] tile_t;

    state_t                  r_state;
    state_t                  w_state_nxt;

    logic [IDX_W-1:0]        r_row;
    logic [IDX_W-1:0]        r_col;
    logic [IDX_W-1:0]        w_row_nxt;
    logic [IDX_W-1:0]        w_col_nxt;

    logic [COUNT_WIDTH-1:0]  r_count;
    logic [COUNT_WIDTH-1:0]  r_tiles_done;
    tile_t                   r_tile_in;
    tile_t                   r_result;
    logic                    r_wait_seen;

    logic                    r_busy;
    logic                    r_done;
    logic                    r_in_ready;
    logic                    r_out_valid;
    logic                    r_out_last;
    logic [DATA_WIDTH-1:0]   r_out_data;

    logic                    w_busy_nxt;
    logic                    w_done_nxt;
    logic                    w_in_ready_nxt;
    logic                    w_out_valid_nxt;
    logic                    w_out_last_nxt;
    logic [DATA_WIDTH-1:0]   w_out_data_nxt;

    logic                    w_in_hs;
    logic                    w_out_hs;
    logic                    w_elem_last;
    logic                    w_last_tile;
    logic                    w_start_acc;
    logic                    w_capture;
    logic                    w_timeout;

    assign w_in_hs     = r_in_ready & bus.in_valid;
    assign w_out_hs    = r_out_valid & bus.out_ready;
    assign w_elem_last = (r_row == IDX_W'(LAST_IDX)) && (r_col == IDX_W'(LAST_IDX));
    assign w_last_tile = ((r_tiles_done + COUNT_WIDTH'(1)) == r_count);
    assign w_start_acc = (r_state == S_IDLE) && i_start;
    // The first WAIT cycle may still see the previous tile's completion flag.
    assign w_capture   = (r_state == S_WAIT) && r_wait_seen && bus.ttu_transform_done;

`ifdef TTS_TIMEOUT_EN
    localparam int unsigned WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_error;

    assign w_timeout = (r_state == S_WAIT) && (r_wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1));
    assign o_error   = r_error;

    // WAIT cycle counter and sticky abort flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
            r_error    <= 1'b0;
        end else begin
            r_wait_cnt <= (r_state == S_WAIT) ? WAIT_W'(r_wait_cnt + WAIT_W'(1)) : '0;
            if (w_start_acc) begin
                r_error <= 1'b0;
            end else if (w_timeout && !w_capture) begin
                r_error <= 1'b1;
            end
        end
    end
`else
    assign w_timeout = 1'b0;
    assign o_error   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, element position and registered-output next values
    always_comb begin
        w_state_nxt    = r_state;
        w_row_nxt      = r_row;
        w_col_nxt      = r_col;
        w_out_data_nxt = r_out_data;

        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt = (i_tile_count != '0) ? S_LOAD : S_DONE;
                    w_row_nxt   = '0;
                    w_col_nxt   = '0;
                end
            end
            S_LOAD: begin
                if (w_in_hs && w_elem_last) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_capture) begin
                    w_state_nxt    = S_DRAIN;
                    w_out_data_nxt = bus.ttu_tile_out[0][0];
                end else if (w_timeout) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DRAIN: begin
                if (w_out_hs && w_elem_last) begin
                    w_state_nxt = w_last_tile ? S_DONE : S_LOAD;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_in_hs || w_out_hs) begin
            if (r_col == IDX_W'(LAST_IDX)) begin
                w_col_nxt = '0;
                w_row_nxt = w_elem_last ? '0 : IDX_W'(r_row + IDX_W'(1));
            end else begin
                w_col_nxt = IDX_W'(r_col + IDX_W'(1));
            end
        end

        if (w_out_hs && !w_elem_last) begin
            w_out_data_nxt = r_result[w_row_nxt][w_col_nxt];
        end

        w_busy_nxt      = (w_state_nxt == S_LOAD) || (w_state_nxt == S_WAIT) ||
                          (w_state_nxt == S_DRAIN);
        w_done_nxt      = (w_state_nxt == S_DONE);
        w_in_ready_nxt  = (w_state_nxt == S_LOAD);
        w_out_valid_nxt = (w_state_nxt == S_DRAIN);
        w_out_last_nxt  = (w_state_nxt == S_DRAIN) && w_last_tile &&
                          (w_row_nxt == IDX_W'(LAST_IDX)) && (w_col_nxt == IDX_W'(LAST_IDX));
    end

    // Datapath: counters, held tile, captured result and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row        <= '0;
            r_col        <= '0;
            r_count      <= '0;
            r_tiles_done <= '0;
            r_tile_in    <= '0;
            r_result     <= '0;
            r_wait_seen  <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_in_ready   <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_last   <= 1'b0;
            r_out_data   <= '0;
        end else begin
            r_row       <= w_row_nxt;
            r_col       <= w_col_nxt;
            r_wait_seen <= (r_state == S_WAIT) && (w_state_nxt == S_WAIT);
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_in_ready  <= w_in_ready_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_last  <= w_out_last_nxt;
            r_out_data  <= w_out_data_nxt;

            if (w_start_acc) begin
                r_count      <= i_tile_count;
                r_tiles_done <= '0;
            end else if (w_out_hs && w_elem_last) begin
                r_tiles_done <= COUNT_WIDTH'(r_tiles_done + COUNT_WIDTH'(1));
            end

            if (w_in_hs) begin
                r_tile_in[r_row][r_col] <= bus.in_data;
            end

            if (w_capture) begin
                r_result <= bus.ttu_tile_out;
            end
        end
    end

    assign o_busy          = r_busy;
    assign o_done          = r_done;
    assign o_tiles_done    = r_tiles_done;
    assign bus.in_ready    = r_in_ready;
    assign bus.out_valid   = r_out_valid;
    assign bus.out_last    = r_out_last;
    assign bus.out_data    = r_out_data;
    assign bus.ttu_tile_in = r_tile_in;

endmodule

// File: tb/tb_tile_transform_scheduler.sv
// Bench for tile_transform_scheduler: cycle-stepped environment with a transform-unit model
// and an expected-result queue built from the elements actually sent.
module tb_tile_transform_scheduler;

    localparam int unsigned DW = 16;
    localparam int unsigned CW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_start;
    logic [CW-1:0] i_tile_count;
    logic          o_busy;
    logic          o_done;
    logic          o_error;
    logic [CW-1:0] o_tiles_done;

    int n_tests = 0;
    int n_fail  = 0;

    tile_transform_scheduler_if #(.DATA_WIDTH(DW)) bus ();

    tile_transform_scheduler #(
        .DATA_WIDTH    (DW),
        .COUNT_WIDTH   (CW),
        .TIMEOUT_CYCLES(10)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_start     (i_start),
        .i_tile_count(i_tile_count),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_error     (o_error),
        .o_tiles_done(o_tiles_done),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string pfx);
        logic [0:5][0:5][DW-1:0] zero_t;
        zero_t = '0;
        chk({pfx, "_busy"},      64'(o_busy),        64'd0);
        chk({pfx, "_done"},      64'(o_done),        64'd0);
        chk({pfx, "_error"},     64'(o_error),       64'd0);
        chk({pfx, "_tiles"},     64'(o_tiles_done),  64'd0);
        chk({pfx, "_in_ready"},  64'(bus.in_ready),  64'd0);
        chk({pfx, "_out_valid"}, 64'(bus.out_valid), 64'd0);
        chk({pfx, "_out_last"},  64'(bus.out_last),  64'd0);
        chk({pfx, "_out_data"},  64'(bus.out_data),  64'd0);
        n_tests++;
        assert (bus.ttu_tile_in === zero_t) else begin
            n_fail++;
            $error("FAIL %s_tile_in: observed %h expected %h", pfx, bus.ttu_tile_in, zero_t);
        end
    endtask

    // One job: cnt tiles, percent gaps on both streams, transform-unit done after dly WAIT cycles
    // (or held high when stale), rev selects a position-reversing transform, abort_at>0 resets
    // the DUT after that many results have been accepted.
    task automatic run_job(input int cnt, input int unsigned in_gap, input int unsigned out_gap,
                           input int dly, input bit stale, input bit rev, input bit seq,
                           input bit poke, input int abort_at);
        logic [DW-1:0]           tile [36];
        logic [DW-1:0]           expq [$];
        logic [DW-1:0]           last_data;
        logic [DW-1:0]           e;
        logic [0:5][0:5][DW-1:0] exp_tin;
        int                      n_in, n_out, wctr, cyc, n_done, eff, total;
        bit                      stalled, wnext;

        n_in = 0; n_out = 0; wctr = 0; cyc = 0; n_done = 0; stalled = 1'b0;
        last_data = '0;
        eff   = stale ? 2 : dly;
        total = cnt * 36;
        foreach (tile[k]) tile[k] = '0;

        @(negedge clk);
        i_start      = 1'b1;
        i_tile_count = CW'(cnt);
        @(negedge clk);
        i_start = 1'b0;
        chk("busy_on_start",     64'(o_busy),       64'd1);
        chk("in_ready_on_start", 64'(bus.in_ready), 64'd1);
        chk("error_clr_on_start", 64'(o_error),     64'd0);

        while (n_out < total && cyc < 20000) begin
            n_done += o_done ? 1 : 0;
            if (abort_at != 0 && n_out == abort_at) break;
            wnext = 1'b0;

            if (wctr == 1) begin
                for (int r = 0; r < 6; r++)
                    for (int c = 0; c < 6; c++)
                        exp_tin[r][c] = tile[r*6 + c];
                n_tests++;
                assert (bus.ttu_tile_in === exp_tin) else begin
                    n_fail++;
                    $error("FAIL tile_in_held: observed %h expected %h", bus.ttu_tile_in, exp_tin);
                end
                chk("in_ready_in_wait", 64'(bus.in_ready), 64'd0);
            end
            if (wctr > 0 && bus.out_valid) begin
                chk("wait_latency", 64'(wctr), 64'(eff + 1));
                wctr = 0;
            end
            if (stalled && bus.out_valid) chk("out_stable", 64'(bus.out_data), 64'(last_data));

            bus.in_valid  = (n_in < total) && ($urandom_range(99) >= in_gap);
            bus.in_data   = seq ? DW'(n_in) : DW'($urandom);
            bus.out_ready = ($urandom_range(99) >= out_gap);
            bus.ttu_transform_done = stale || (wctr == dly);
            for (int r = 0; r < 6; r++)
                for (int c = 0; c < 6; c++)
                    bus.ttu_tile_out[r][c] = (wctr >= 2) ?
                        DW'(tile[rev ? 35 - (r*6 + c) : r*6 + c] + DW'(100)) : DW'(16'hDEAD);

            if (bus.in_valid && bus.in_ready) begin
                tile[n_in % 36] = bus.in_data;
                n_in++;
                if (n_in % 36 == 0) begin
                    for (int k = 0; k < 36; k++) expq.push_back(DW'(tile[rev ? 35 - k : k] + DW'(100)));
                    wnext = 1'b1;
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                if (expq.size() == 0) begin
                    chk("out_unexpected", 64'd1, 64'd0);
                end else begin
                    e = expq.pop_front();
                    chk("out_data", 64'(bus.out_data), 64'(e));
                end
                chk("out_last", 64'(bus.out_last), 64'(n_out == total - 1));
                n_out++;
            end
            stalled   = bus.out_valid && !bus.out_ready;
            last_data = bus.out_data;

            if (poke) begin
                i_start      = (cyc >= 3 && cyc <= 6) || (cyc >= 40 && cyc <= 42);
                i_tile_count = CW'(7);
            end
            if (wctr > 0) wctr++;
            if (wnext) wctr = 1;
            cyc++;
            @(negedge clk);
        end

        i_start = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.ttu_transform_done = 1'b0;

        if (abort_at != 0) begin
            chk("abort_outputs_seen", 64'(n_out), 64'(abort_at));
            rst_n = 1'b0;
            #1;
            chk_reset_vals("abort");
            repeat (3) begin
                @(negedge clk);
                n_done += o_done ? 1 : 0;
            end
            chk("abort_no_done", 64'(n_done), 64'd0);
            rst_n = 1'b1;
            return;
        end

        chk("job_in_budget", 64'(cyc < 20000), 64'd1);
        chk("no_early_done", 64'(n_done), 64'd0);
        chk("no_leftover",   64'(expq.size()), 64'd0);
        if (in_gap == 0 && out_gap == 0) chk("job_cycles", 64'(cyc), 64'(cnt * (72 + eff)));
        chk("done_pulse",    64'(o_done),       64'd1);
        chk("busy_in_done",  64'(o_busy),       64'd0);
        chk("tiles_done",    64'(o_tiles_done), 64'(cnt));
        chk("error_normal",  64'(o_error),      64'd0);
        chk("out_valid_end", 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        chk("done_one_cycle", 64'(o_done),       64'd0);
        chk("tiles_hold",     64'(o_tiles_done), 64'(cnt));
    endtask

    initial begin
        rst_n = 1'b0;
        i_start = 1'b0;
        i_tile_count = '0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b0;
        bus.ttu_transform_done = 1'b0;
        bus.ttu_tile_out = '0;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Single tile, inputs 0..35, done 3 cycles into WAIT, results 100..135
        run_job(1, 0, 0, 3, 1'b0, 1'b0, 1'b1, 1'b0, 0);

        // Three tiles with random gaps on both streams
        run_job(3, 30, 35, int'($urandom_range(2, 5)), 1'b0, 1'b1, 1'b0, 1'b0, 0);

        // Zero-count job
        @(negedge clk);
        i_start = 1'b1;
        i_tile_count = '0;
        @(negedge clk);
        i_start = 1'b0;
        chk("zero_done",     64'(o_done),       64'd1);
        chk("zero_busy",     64'(o_busy),       64'd0);
        chk("zero_in_ready", 64'(bus.in_ready), 64'd0);
        @(negedge clk);
        chk("zero_done_end", 64'(o_done),       64'd0);
        chk("zero_busy_end", 64'(o_busy),       64'd0);
        chk("zero_in_ready_end", 64'(bus.in_ready), 64'd0);

        // Completion flag stuck high, with start pulsed while busy
        run_job(2, 0, 0, 2, 1'b1, 1'b1, 1'b0, 1'b1, 0);

`ifdef TTS_TIMEOUT_EN
        begin
            int wc;
            @(negedge clk);
            i_start = 1'b1;
            i_tile_count = CW'(2);
            @(negedge clk);
            i_start = 1'b0;
            bus.ttu_transform_done = 1'b0;
            bus.out_ready = 1'b1;
            for (int k = 0; k < 36; k++) begin
                bus.in_valid = 1'b1;
                bus.in_data  = DW'($urandom);
                @(negedge clk);
            end
            bus.in_valid = 1'b0;
            wc = 1;
            while (!o_done && wc < 100) begin
                @(negedge clk);
                wc++;
            end
            chk("timeout_cycle", 64'(wc),           64'd11);
            chk("timeout_error", 64'(o_error),      64'd1);
            chk("timeout_tiles", 64'(o_tiles_done), 64'd0);
            chk("timeout_busy",  64'(o_busy),       64'd0);
            @(negedge clk);
            chk("timeout_error_sticky", 64'(o_error), 64'd1);
        end
        run_job(1, 10, 10, 3, 1'b0, 1'b1, 1'b0, 1'b0, 0);
`endif

        // Reset during DRAIN after 17 results, then a clean job
        run_job(1, 0, 0, 3, 1'b0, 1'b1, 1'b0, 1'b0, 17);
        @(negedge clk);
        run_job(2, 20, 20, 4, 1'b0, 1'b1, 1'b0, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
